// File: rtl/image_loader.sv
// Image loader: turns a UART byte stream of the form
//   0xAA, width, height, width*height pixels (row-major)
// into single-cycle pixel writes for a frame RAM. Writes are issued one
// clock after the byte strobe. A frame is abandoned and an error pulse is
// raised when the header is invalid or the sender goes quiet for too long.
module image_loader #(
  parameter int ADDR_WIDTH   = 16,
  parameter int TIMEOUT_CLKS = 500000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Wr_En,
  output logic [ADDR_WIDTH-1:0] o_Wr_Addr,
  output logic [7:0]            o_Wr_Data,
  output logic [7:0]            o_Width,
  output logic [7:0]            o_Height,
  output logic                  o_Busy,
  output logic                  o_Frame_Done,
  output logic                  o_Error
);

  // The idle counter only has to reach TIMEOUT_CLKS-1, so it needs
  // clog2(TIMEOUT_CLKS) bits (at least one).
  localparam int TO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TO_W-1:0]       TO_TERM   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TO_W-1:0]       TO_ONE    = TO_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [7:0]            SYNC_BYTE = 8'hAA;

  typedef enum logic [1:0] {
    S_SYNC,
    S_WIDTH,
    S_HEIGHT,
    S_PIXELS
  } state_t;

  state_t state_q, state_d;

  // Header and frame bookkeeping
  logic [7:0]            width_q, width_d;
  logic [7:0]            height_q, height_d;
  logic [ADDR_WIDTH-1:0] total_q, total_d;
  logic [ADDR_WIDTH-1:0] pixCnt_q, pixCnt_d;
  logic [TO_W-1:0]       toCnt_q, toCnt_d;

  // Registered write port and status pulses
  logic                  wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;
  logic [7:0]            wrData_q, wrData_d;
  logic                  frameDone_q, frameDone_d;
  logic                  error_q, error_d;

  // FSM decisions shared with the datapath
  logic                  loadWidth;
  logic                  loadHeight;
  logic                  startFrame;
  logic                  writePixel;
  logic                  lastPixel;
  logic                  timeoutHit;
  logic [15:0]           product;

  // Full 8x8 product; it is resized to the address width when latched,
  // which truncates for narrow address buses.
  assign product    = {8'd0, width_q} * {8'd0, i_Rx_Byte};
  assign lastPixel  = (pixCnt_q == (total_q - ADDR_ONE));
  // A byte arriving on the terminal count wins over the timeout.
  assign timeoutHit = (state_q != S_SYNC) && !i_Rx_DV && (toCnt_q == TO_TERM);

  // Next-state logic and per-byte control decisions
  always_comb begin
    state_d     = state_q;
    loadWidth   = 1'b0;
    loadHeight  = 1'b0;
    startFrame  = 1'b0;
    writePixel  = 1'b0;
    frameDone_d = 1'b0;
    error_d     = 1'b0;

    if (i_Rx_DV) begin
      case (state_q)
        S_SYNC: begin
          if (i_Rx_Byte == SYNC_BYTE) begin
            state_d = S_WIDTH;
          end
        end
        S_WIDTH: begin
          loadWidth = 1'b1;
          if (i_Rx_Byte == 8'd0) begin
            error_d = 1'b1;
            state_d = S_SYNC;
          end else begin
            state_d = S_HEIGHT;
          end
        end
        S_HEIGHT: begin
          loadHeight = 1'b1;
          if (i_Rx_Byte == 8'd0) begin
            error_d = 1'b1;
            state_d = S_SYNC;
          end else begin
            startFrame = 1'b1;
            state_d    = S_PIXELS;
          end
        end
        S_PIXELS: begin
          // 0xAA is ordinary pixel data here, never a resync.
          writePixel = 1'b1;
          if (lastPixel) begin
            frameDone_d = 1'b1;
            state_d     = S_SYNC;
          end
        end
        default: begin
          state_d = S_SYNC;
        end
      endcase
    end else if (timeoutHit) begin
      error_d = 1'b1;
      state_d = S_SYNC;
    end
  end

  // Datapath next values: header capture, pixel counter, idle counter, write port
  always_comb begin
    width_d  = loadWidth  ? i_Rx_Byte : width_q;
    height_d = loadHeight ? i_Rx_Byte : height_q;
    total_d  = startFrame ? ADDR_WIDTH'(product) : total_q;

    pixCnt_d = pixCnt_q;
    if (startFrame) begin
      pixCnt_d = '0;
    end else if (writePixel) begin
      pixCnt_d = pixCnt_q + ADDR_ONE;
    end

    // Any received byte or a return to S_SYNC restarts the idle count;
    // otherwise it advances every clock while a frame is in progress.
    if (i_Rx_DV || (state_d == S_SYNC)) begin
      toCnt_d = '0;
    end else begin
      toCnt_d = toCnt_q + TO_ONE;
    end

    wrEn_d   = writePixel;
    wrAddr_d = writePixel ? pixCnt_q  : wrAddr_q;
    wrData_d = writePixel ? i_Rx_Byte : wrData_q;
  end

  // FSM state register
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Header, frame size and counters
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      width_q  <= '0;
      height_q <= '0;
      total_q  <= '0;
      pixCnt_q <= '0;
      toCnt_q  <= '0;
    end else begin
      width_q  <= width_d;
      height_q <= height_d;
      total_q  <= total_d;
      pixCnt_q <= pixCnt_d;
      toCnt_q  <= toCnt_d;
    end
  end

  // Registered write port and status pulses
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      frameDone_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wrEn_q      <= wrEn_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      frameDone_q <= frameDone_d;
      error_q     <= error_d;
    end
  end

  assign o_Wr_En      = wrEn_q;
  assign o_Wr_Addr    = wrAddr_q;
  assign o_Wr_Data    = wrData_q;
  assign o_Width      = width_q;
  assign o_Height     = height_q;
  assign o_Busy       = (state_q != S_SYNC);
  assign o_Frame_Done = frameDone_q;
  assign o_Error      = error_q;

  // Completion needs a byte and a timeout needs its absence, so the two
  // pulses can never coincide.
  assert property (@(posedge i_Clock) disable iff (i_Reset) !(o_Frame_Done && o_Error));

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader. A small reference model of the packet
// format predicts every pixel write into a scoreboard queue as bytes are
// driven; a negedge monitor pops and compares each write the DUT produces.
module tb_image_loader;

  localparam int ADDR_WIDTH   = 16;
  localparam int TIMEOUT_CLKS = 100;

  logic                  i_Clock = 1'b0;
  logic                  i_Reset;
  logic                  i_Rx_DV;
  logic [7:0]            i_Rx_Byte;
  logic                  o_Wr_En;
  logic [ADDR_WIDTH-1:0] o_Wr_Addr;
  logic [7:0]            o_Wr_Data;
  logic [7:0]            o_Width;
  logic [7:0]            o_Height;
  logic                  o_Busy;
  logic                  o_Frame_Done;
  logic                  o_Error;

  image_loader #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .o_Wr_En     (o_Wr_En),
    .o_Wr_Addr   (o_Wr_Addr),
    .o_Wr_Data   (o_Wr_Data),
    .o_Width     (o_Width),
    .o_Height    (o_Height),
    .o_Busy      (o_Busy),
    .o_Frame_Done(o_Frame_Done),
    .o_Error     (o_Error)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        last;
  } wrExp_t;

  wrExp_t      sbQ[$];
  wrExp_t      monExp;
  int          testsRun  = 0;
  int          failCount = 0;
  int          errSeen   = 0;
  int          expErr    = 0;
  int          doneSeen  = 0;
  int          expDone   = 0;
  logic [15:0] lastDoneAddr = '0;

  // Reference model state: 0 sync, 1 width, 2 height, 3 pixels
  int mState = 0;
  int mW     = 0;
  int mH     = 0;
  int mTotal = 0;
  int mCnt   = 0;

  int   errCycle;
  logic busyBefore;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one byte for one clock and let the model predict its effect
  task automatic applyStimulus(input logic [7:0] b);
    wrExp_t e;
    @(negedge i_Clock);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    case (mState)
      0: if (b == 8'hAA) mState = 1;
      1: begin
        mW = int'(b);
        if (b == 8'd0) begin
          expErr++;
          mState = 0;
        end else begin
          mState = 2;
        end
      end
      2: begin
        mH = int'(b);
        if (b == 8'd0) begin
          expErr++;
          mState = 0;
        end else begin
          mTotal = mW * mH;
          mCnt   = 0;
          mState = 3;
        end
      end
      default: begin
        e.addr = 16'(mCnt);
        e.data = b;
        e.last = (mCnt == mTotal - 1);
        sbQ.push_back(e);
        if (e.last) begin
          expDone++;
          mState = 0;
        end
        mCnt++;
      end
    endcase
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge i_Clock);
      i_Rx_DV = 1'b0;
    end
  endtask

  // Write monitor: every strobe must match the oldest predicted write
  always @(negedge i_Clock) begin
    if (o_Wr_En) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_write", 32'(o_Wr_En), 32'd0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("wr_addr", 32'(o_Wr_Addr), 32'(monExp.addr));
        checkOutput("wr_data", 32'(o_Wr_Data), 32'(monExp.data));
        checkOutput("frame_done_on_write", 32'(o_Frame_Done), 32'(monExp.last));
        if (o_Frame_Done) lastDoneAddr = o_Wr_Addr;
      end
    end
    if (o_Frame_Done) begin
      doneSeen++;
      checkOutput("done_with_wren", 32'(o_Wr_En), 32'd1);
    end
    if (o_Error) begin
      errSeen++;
      checkOutput("error_excl_done", 32'(o_Frame_Done), 32'd0);
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_Reset   = 1'b1;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
    repeat (3) @(negedge i_Clock);

    // Reset state
    checkOutput("rst_wr_en",  32'(o_Wr_En), 32'd0);
    checkOutput("rst_addr",   32'(o_Wr_Addr), 32'd0);
    checkOutput("rst_data",   32'(o_Wr_Data), 32'd0);
    checkOutput("rst_width",  32'(o_Width), 32'd0);
    checkOutput("rst_height", 32'(o_Height), 32'd0);
    checkOutput("rst_busy",   32'(o_Busy), 32'd0);
    checkOutput("rst_done",   32'(o_Frame_Done), 32'd0);
    checkOutput("rst_error",  32'(o_Error), 32'd0);
    i_Reset = 1'b0;

    // 2x2 frame: four writes, done with the fourth, one cycle latency
    applyStimulus(8'hAA);
    applyStimulus(8'h02);
    applyStimulus(8'h02);
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h30);
    applyStimulus(8'h40);
    idleCycles(1);
    checkOutput("f1_last_wren",  32'(o_Wr_En), 32'd1);
    checkOutput("f1_last_done",  32'(o_Frame_Done), 32'd1);
    checkOutput("f1_last_addr",  32'(o_Wr_Addr), 32'd3);
    checkOutput("f1_width",      32'(o_Width), 32'd2);
    checkOutput("f1_height",     32'(o_Height), 32'd2);
    idleCycles(1);
    checkOutput("f1_busy_after", 32'(o_Busy), 32'd0);
    checkOutput("f1_done_pulse", 32'(o_Frame_Done), 32'd0);
    checkOutput("f1_wren_pulse", 32'(o_Wr_En), 32'd0);
    checkOutput("f1_addr_hold",  32'(o_Wr_Addr), 32'd3);
    checkOutput("f1_data_hold",  32'(o_Wr_Data), 32'h40);

    // Junk before sync is ignored; 1x1 frame
    applyStimulus(8'h55);
    applyStimulus(8'h13);
    idleCycles(1);
    checkOutput("junk_not_busy", 32'(o_Busy), 32'd0);
    applyStimulus(8'hAA);
    idleCycles(1);
    checkOutput("sync_busy", 32'(o_Busy), 32'd1);
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    applyStimulus(8'h7F);
    idleCycles(2);
    checkOutput("f2_width",  32'(o_Width), 32'd1);
    checkOutput("f2_height", 32'(o_Height), 32'd1);
    checkOutput("f2_done_count", 32'(doneSeen), 32'(expDone));

    // 0xAA inside the pixel stream is data
    applyStimulus(8'hAA);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'hAA);
    applyStimulus(8'h33);
    idleCycles(2);
    checkOutput("aa_pixel_done_count", 32'(doneSeen), 32'(expDone));

    // Zero width, then a good frame; zero height also errors
    applyStimulus(8'hAA);
    applyStimulus(8'h00);
    idleCycles(2);
    checkOutput("zero_w_error", 32'(errSeen), 32'(expErr));
    checkOutput("zero_w_idle",  32'(o_Busy), 32'd0);
    applyStimulus(8'hAA);
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    applyStimulus(8'h05);
    idleCycles(2);
    checkOutput("after_err_sb_empty", 32'(sbQ.size()), 32'd0);
    applyStimulus(8'hAA);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    idleCycles(2);
    checkOutput("zero_h_error", 32'(errSeen), 32'(expErr));

    // Byte arriving exactly on the timeout terminal count is accepted
    applyStimulus(8'hAA);
    applyStimulus(8'h02);
    applyStimulus(8'h01);
    idleCycles(TIMEOUT_CLKS - 1);
    applyStimulus(8'h66);
    idleCycles(1);
    checkOutput("tc_no_error", 32'(errSeen), 32'(expErr));
    checkOutput("tc_still_busy", 32'(o_Busy), 32'd1);
    applyStimulus(8'h77);
    idleCycles(2);
    checkOutput("tc_done_count", 32'(doneSeen), 32'(expDone));

    // Timeout: one write, then an error 100 clocks after that write
    applyStimulus(8'hAA);
    applyStimulus(8'h03);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    errCycle   = -1;
    busyBefore = 1'b0;
    for (int n = 1; n <= 3 * TIMEOUT_CLKS; n++) begin
      @(negedge i_Clock);
      i_Rx_DV = 1'b0;
      if (n == TIMEOUT_CLKS) busyBefore = o_Busy;
      if (o_Error) begin
        errCycle = n;
        break;
      end
    end
    expErr++;
    mState = 0;
    checkOutput("to_latency", 32'(errCycle), 32'(TIMEOUT_CLKS + 1));
    checkOutput("to_busy_before", 32'(busyBefore), 32'd1);
    checkOutput("to_busy_falls", 32'(o_Busy), 32'd0);
    idleCycles(2);
    checkOutput("to_error_count", 32'(errSeen), 32'(expErr));
    checkOutput("to_single_write", 32'(sbQ.size()), 32'd0);

    // Asynchronous reset mid-frame while a write strobe is high
    applyStimulus(8'hAA);
    applyStimulus(8'h02);
    applyStimulus(8'h02);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    idleCycles(1);
    #2;
    i_Reset = 1'b1;
    #1;
    mState = 0;
    checkOutput("ar_wr_en",  32'(o_Wr_En), 32'd0);
    checkOutput("ar_addr",   32'(o_Wr_Addr), 32'd0);
    checkOutput("ar_data",   32'(o_Wr_Data), 32'd0);
    checkOutput("ar_width",  32'(o_Width), 32'd0);
    checkOutput("ar_height", 32'(o_Height), 32'd0);
    checkOutput("ar_busy",   32'(o_Busy), 32'd0);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    idleCycles(2);
    checkOutput("ar_ignored_busy", 32'(o_Busy), 32'd0);
    applyStimulus(8'hAA);
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    applyStimulus(8'h09);
    idleCycles(2);
    checkOutput("ar_resync_sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("ar_resync_width", 32'(o_Width), 32'd1);

    // Full-size 255x255 frame, bytes back to back
    applyStimulus(8'hAA);
    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    for (int i = 0; i < 255 * 255; i++) begin
      applyStimulus(8'(i));
    end
    idleCycles(2);
    checkOutput("big_last_addr", 32'(lastDoneAddr), 32'h0000FE00);
    checkOutput("big_sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("big_done_count", 32'(doneSeen), 32'(expDone));
    checkOutput("big_error_count", 32'(errSeen), 32'(expErr));
    checkOutput("big_busy_after", 32'(o_Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
